tu_border_sched: RTL and testbench
==================================

// Module: tu_border_sched
// PURPOSE
//  Scheduler for one row-border input of the unary-temporal systolic array.
//  - Accepts signed operands over a valid/ready handshake and holds each in a border register.
//  - Converts the operand to sign + magnitude.
//  - Plays the magnitude out as a temporal-unary bitstream over a fixed window.
//  - Window-start/last strobes sequence the PE row; back-to-back windows run with no bubble.
// PARAMETERS
//  WIDTH  16  operand width, two's complement; magnitude is WIDTH-1 bits; window N = 2**(WIDTH-1)
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous active-low reset
//  clr          in   1      synchronous abort: return to IDLE, drop held operand
//  i_valid      in   1      operand valid
//  o_ready      out  1      operand accepted when i_valid & o_ready
//  i_data       in   WIDTH  signed operand
//  i_stall      in   1      downstream hold; freezes counter and all outputs
//  o_sign       out  1      sign of the operand in the current window
//  o_bit        out  1      temporal-unary bit: 1 while cnt < magnitude
//  o_win_start  out  1      first cycle of a window (cnt==0)
//  o_win_last   out  1      last cycle of a window (cnt==N-1)
//  o_busy       out  1      window in progress (state STREAM)
// BEHAVIOUR
//  - Reset: state IDLE; cnt=0; held operand=0; o_sign, o_bit, o_win_start, o_win_last, o_busy = 0.
//  - States: IDLE, STREAM.
//    - IDLE -> STREAM on accept.
//    - STREAM -> STREAM on accept during last cycle: cnt wraps to 0, new operand loaded.
//    - STREAM -> IDLE at end of the last cycle when there is no accept.
//  - o_ready = (state==IDLE) | (o_win_last & ~i_stall); combinational; never depends on i_valid.
//  - Latency: accept at cycle t -> o_win_start=1 and bit for cnt=0 at cycle t+1.
//  - Magnitude: |i_data|, computed at accept.
//    - Most-negative input saturates to 2**(WIDTH-1)-1, with sign=1.
//    - 0 and -0 are not distinct: i_data=0 gives sign 0 and magnitude 0.
//  - o_bit = (cnt < mag); registered and driven in the same cycle as cnt.
//    - Ones-count per window equals mag exactly.
//  - i_stall=1 in STREAM: cnt, operand, state and outputs hold; o_ready=0 unless state==IDLE.
//  - i_stall in IDLE: no effect; accept still allowed.
//  - clr: overrides accept and stall; next cycle matches reset values.
//  - rst_n mid-window: immediate return to reset values; no partial window resumes.
//  - The counter is WIDTH-1 bits and wraps only under the rules above; cnt never exceeds N-1.
// CONFIGURATION
//  - TU_EARLY_TERM_EN defined:
//    - Adds input cfg_len_log2, width $clog2(WIDTH), sampled at each accept; legal range 1..WIDTH-1.
//    - Window length L = 2**cfg_len_log2.
//    - Magnitude is truncated: mag_t = mag >> (WIDTH-1-cfg_len_log2).
//    - o_bit = (cnt < mag_t); o_win_last at cnt==L-1.
//    - Values outside the legal range clamp to WIDTH-1.
//  - TU_EARLY_TERM_EN undefined: no cfg_len_log2 port; window fixed at N; behaviour as above.
// STRUCTURE
//  - Package tu_pkg holds:
//    - typedef enum logic {IDLE, STREAM} tu_state_e;
//    - function tu_win_len(width) returning 2**(width-1).
//    - typedef for the magnitude vector.
//  - Sub-module tu_abs_sign: combinational sign/magnitude split with saturation.
//    - Instantiated once on i_data at the accept path.
//  - Top holds: FSM, counter, operand register, output registers.
// TESTING  (WIDTH=4, N=8 unless noted)
//  - i_data=3, single accept -> o_bit 1,1,1,0,0,0,0,0; o_sign=0; o_win_start at cycle 1;
//    o_win_last at cycle 8; then IDLE.
//  - i_data=-8 -> o_sign=1; 7 ones then 1 zero. i_data=0 -> 8 zeros, o_sign=0.
//  - Back-to-back +2, -5, i_valid held high -> 16 contiguous cycles, no bubble;
//    ones-counts 2 then 5; o_sign 0 then 1; o_ready high only on the last cycle of each window.
//  - i_data=5, i_stall=1 at cnt=3 for 4 cycles -> outputs frozen;
//    total window 12 cycles, still exactly 5 ones.
//  - i_data=6, clr at cnt=2 -> next cycle all outputs 0, o_ready=1;
//    new accept i_data=1 -> fresh window with 1 one.
//  - TU_EARLY_TERM_EN, cfg_len_log2=2, i_data=-6 -> window 4 cycles;
//    o_bit 1,1,1,0; o_sign=1; o_win_last at cnt=3.

Source files
------------

// File: rtl/tu_pkg.sv
// rtl/tu_pkg.sv - shared types and helpers for the temporal-unary border scheduler
package tu_pkg;

  typedef enum logic {IDLE, STREAM} tu_state_e;

  localparam int TU_WIDTH = 16;

  typedef logic [TU_WIDTH-2:0] tu_mag_t;

  function automatic int tu_win_len(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/tu_abs_sign.sv
// rtl/tu_abs_sign.sv - combinational sign/magnitude split; most-negative saturates to max magnitude
module tu_abs_sign #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  output logic             sign,
  output logic [WIDTH-2:0] mag
);

  localparam logic [WIDTH-2:0] ONE = (WIDTH-1)'(1);

  logic [WIDTH-2:0] neg_low;

  always_comb begin
    // Low bits of -data equal ~data+1 truncated; the top bit is never needed.
    neg_low = ~data[WIDTH-2:0] + ONE;
    sign    = data[WIDTH-1];
    if (data == {1'b1, {(WIDTH-1){1'b0}}}) begin
      mag = '1;
    end else if (sign) begin
      mag = neg_low;
    end else begin
      mag = data[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/tu_border_sched.sv
// rtl/tu_border_sched.sv - row-border operand scheduler emitting temporal-unary windows; optional TU_EARLY_TERM_EN
module tu_border_sched
  import tu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_data,
`ifdef TU_EARLY_TERM_EN
  input  logic [$clog2(WIDTH)-1:0] cfg_len_log2,
`endif
  input  logic                     i_stall,
  output logic                     o_sign,
  output logic                     o_bit,
  output logic                     o_win_start,
  output logic                     o_win_last,
  output logic                     o_busy
);

  localparam int               MW       = WIDTH - 1;
  localparam logic [MW-1:0]    CNT_LAST = MW'(tu_win_len(WIDTH) - 1);
  localparam logic [MW-1:0]    CNT_ONE  = MW'(1);

  tu_state_e       state, state_n;
  logic [MW-1:0]   cnt, cnt_n;
  logic [MW-1:0]   mag_q, mag_n;
  logic            sign_q, sign_n;
  logic            abs_sign;
  logic [MW-1:0]   abs_mag;
  logic [MW-1:0]   acc_mag, acc_last, last_val, last_next;
  logic            accept;
  logic            bit_n, start_n, wlast_n, osign_n;

  tu_abs_sign #(.WIDTH(WIDTH)) u_abs_sign (
    .data (i_data),
    .sign (abs_sign),
    .mag  (abs_mag)
  );

`ifdef TU_EARLY_TERM_EN
  localparam int                LW      = $clog2(WIDTH);
  localparam logic [LW-1:0]     LEN_MAX = LW'(WIDTH - 1);

  logic [LW-1:0] len_c;
  logic [MW-1:0] last_q, last_n;

  always_comb begin
    len_c = cfg_len_log2;
    if (cfg_len_log2 == '0 || cfg_len_log2 > LEN_MAX) begin
      len_c = LEN_MAX;
    end
    acc_mag  = abs_mag >> (LEN_MAX - len_c);
    acc_last = (CNT_ONE << len_c) - CNT_ONE;
  end

  assign last_val = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= CNT_LAST;
    end else begin
      last_q <= last_n;
    end
  end
`else
  assign acc_mag  = abs_mag;
  assign acc_last = CNT_LAST;
  assign last_val = CNT_LAST;
`endif

  assign o_ready = (state == IDLE) | (o_win_last & ~i_stall);
  assign accept  = i_valid & o_ready & ~clr;
  assign o_busy  = (state == STREAM);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mag_n     = mag_q;
    sign_n    = sign_q;
    last_next = last_val;
    if (clr) begin
      state_n   = IDLE;
      cnt_n     = '0;
      mag_n     = '0;
      sign_n    = 1'b0;
      last_next = CNT_LAST;
    end else if (accept) begin
      state_n   = STREAM;
      cnt_n     = '0;
      mag_n     = acc_mag;
      sign_n    = abs_sign;
      last_next = acc_last;
    end else if (state == STREAM && !i_stall) begin
      if (cnt == last_val) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + CNT_ONE;
      end
    end
    // Outputs are registered from the next-cycle view so they line up with cnt.
    bit_n   = (state_n == STREAM) && (cnt_n < mag_n);
    start_n = (state_n == STREAM) && (cnt_n == '0);
    wlast_n = (state_n == STREAM) && (cnt_n == last_next);
    osign_n = (state_n == STREAM) && sign_n;
  end

`ifdef TU_EARLY_TERM_EN
  assign last_n = last_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mag_q       <= '0;
      sign_q      <= 1'b0;
      o_bit       <= 1'b0;
      o_win_start <= 1'b0;
      o_win_last  <= 1'b0;
      o_sign      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mag_q       <= mag_n;
      sign_q      <= sign_n;
      o_bit       <= bit_n;
      o_win_start <= start_n;
      o_win_last  <= wlast_n;
      o_sign      <= osign_n;
    end
  end

endmodule

// File: tb/tb_tu_border_sched.sv
// tb/tb_tu_border_sched.sv - directed self-checking bench for tu_border_sched at WIDTH=4
module tb_tu_border_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_data;
  logic       i_stall;
  logic       o_sign, o_bit, o_win_start, o_win_last, o_busy;
`ifdef TU_EARLY_TERM_EN
  logic [1:0] cfg_len_log2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tu_border_sched #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
`ifdef TU_EARLY_TERM_EN
    .cfg_len_log2 (cfg_len_log2),
`endif
    .i_stall      (i_stall),
    .o_sign       (o_sign),
    .o_bit        (o_bit),
    .o_win_start  (o_win_start),
    .o_win_last   (o_win_last),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] d);
    i_valid = 1'b1;
    i_data  = d;
    step();
    i_valid = 1'b0;
  endtask

  task automatic capture(input int max_len, output logic [31:0] bits, output int len,
                         output int ones, output int starts, output int last_idx,
                         output logic sgn);
    bits = '0; len = 0; ones = 0; starts = 0; last_idx = -1; sgn = 1'b0;
    while (o_busy && len < max_len) begin
      bits[len] = o_bit;
      ones += int'(o_bit);
      if (o_win_start) starts++;
      if (o_win_last) last_idx = len;
      sgn = o_sign;
      len++;
      step();
    end
  endtask

  task automatic test_reset();
    n_checks++; if ({o_sign, o_bit, o_win_start, o_win_last, o_busy} !== 5'b0) begin n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {o_sign, o_bit, o_win_start, o_win_last, o_busy}); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_single();
    logic [31:0] bits; int len, ones, starts, last_idx; logic sgn;
    accept(4'd3);
    capture(20, bits, len, ones, starts, last_idx, sgn);
    n_checks++; if (bits[7:0] !== 8'b0000_0111) begin n_fail++;
      $display("FAIL single_bits: got %b expected 00000111", bits[7:0]); end
    n_checks++; if (len !== 8 || starts !== 1 || last_idx !== 7) begin n_fail++;
      $display("FAIL single_frame: got len=%0d starts=%0d last=%0d expected 8 1 7", len, starts, last_idx); end
    n_checks++; if (sgn !== 1'b0 || o_busy !== 1'b0) begin n_fail++;
      $display("FAIL single_sign_idle: got sign=%b busy=%b expected 0 0", sgn, o_busy); end
  endtask

  task automatic test_neg_zero();
    logic [31:0] bits; int len, ones, starts, last_idx; logic sgn;
    accept(4'h8);
    capture(20, bits, len, ones, starts, last_idx, sgn);
    n_checks++; if (bits[7:0] !== 8'b0111_1111 || sgn !== 1'b1) begin n_fail++;
      $display("FAIL most_neg: got bits=%b sign=%b expected 01111111 1", bits[7:0], sgn); end
    accept(4'h0);
    capture(20, bits, len, ones, starts, last_idx, sgn);
    n_checks++; if (ones !== 0 || sgn !== 1'b0 || len !== 8) begin n_fail++;
      $display("FAIL zero: got ones=%0d sign=%b len=%0d expected 0 0 8", ones, sgn, len); end
  endtask

  task automatic test_back_to_back();
    int ones_a = 0, ones_b = 0, bubbles = 0, bad_ready = 0;
    logic sgn_a, sgn_b;
    i_valid = 1'b1; i_data = 4'd2;
    step();
    i_data = 4'hB;
    for (int idx = 0; idx < 16; idx++) begin
      if (idx == 15) i_valid = 1'b0;
      if (!o_busy) bubbles++;
      if (o_ready !== (idx == 7 || idx == 15)) bad_ready++;
      if (idx < 8) ones_a += int'(o_bit); else ones_b += int'(o_bit);
      if (idx == 0) sgn_a = o_sign;
      if (idx == 8) sgn_b = o_sign;
      step();
    end
    i_valid = 1'b0;
    n_checks++; if (ones_a !== 2 || ones_b !== 5) begin n_fail++;
      $display("FAIL b2b_ones: got %0d,%0d expected 2,5", ones_a, ones_b); end
    n_checks++; if (sgn_a !== 1'b0 || sgn_b !== 1'b1) begin n_fail++;
      $display("FAIL b2b_sign: got %b,%b expected 0,1", sgn_a, sgn_b); end
    n_checks++; if (bubbles !== 0 || bad_ready !== 0) begin n_fail++;
      $display("FAIL b2b_flow: got bubbles=%0d bad_ready=%0d expected 0 0", bubbles, bad_ready); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++;
      $display("FAIL b2b_end: got busy=%b expected 0", o_busy); end
  endtask

  task automatic test_stall();
    int len = 0, ones = 0, frozen_bad = 0;
    accept(4'd5);
    while (o_busy && len < 30) begin
      if (len == 3) i_stall = 1'b1;
      if (len == 7) i_stall = 1'b0;
      if (i_stall && (o_ready !== 1'b0 || o_bit !== 1'b1 || o_win_start !== 1'b0)) frozen_bad++;
      if (!i_stall) ones += int'(o_bit);
      len++;
      step();
    end
    i_stall = 1'b0;
    n_checks++; if (len !== 12) begin n_fail++;
      $display("FAIL stall_len: got %0d expected 12", len); end
    n_checks++; if (ones !== 5 || frozen_bad !== 0) begin n_fail++;
      $display("FAIL stall_ones: got ones=%0d frozen_bad=%0d expected 5 0", ones, frozen_bad); end
  endtask

  task automatic test_clr();
    logic [31:0] bits; int len, ones, starts, last_idx; logic sgn;
    accept(4'd6);
    step(); step();
    clr = 1'b1; i_valid = 1'b1; i_data = 4'd7;
    step();
    clr = 1'b0; i_valid = 1'b0;
    n_checks++; if ({o_sign, o_bit, o_win_start, o_win_last, o_busy} !== 5'b0 || o_ready !== 1'b1) begin n_fail++;
      $display("FAIL clr_outputs: got %b ready=%b expected 00000 1", {o_sign, o_bit, o_win_start, o_win_last, o_busy}, o_ready); end
    accept(4'd1);
    capture(20, bits, len, ones, starts, last_idx, sgn);
    n_checks++; if (bits[7:0] !== 8'b0000_0001 || len !== 8) begin n_fail++;
      $display("FAIL clr_fresh: got bits=%b len=%0d expected 00000001 8", bits[7:0], len); end
  endtask

  task automatic test_async_reset();
    accept(4'd3);
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({o_bit, o_win_start, o_busy} !== 3'b0 || o_ready !== 1'b1) begin n_fail++;
      $display("FAIL async_reset: got %b ready=%b expected 000 1", {o_bit, o_win_start, o_busy}, o_ready); end
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_no_resume: got busy=%b expected 0", o_busy); end
  endtask

`ifdef TU_EARLY_TERM_EN
  task automatic test_early_term();
    logic [31:0] bits; int len, ones, starts, last_idx; logic sgn;
    cfg_len_log2 = 2'd2;
    accept(4'hA);
    capture(20, bits, len, ones, starts, last_idx, sgn);
    n_checks++; if (bits[3:0] !== 4'b0111 || len !== 4 || last_idx !== 3 || sgn !== 1'b1) begin n_fail++;
      $display("FAIL early_term: got bits=%b len=%0d last=%0d sign=%b expected 0111 4 3 1", bits[3:0], len, last_idx, sgn); end
    cfg_len_log2 = 2'd0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; clr = 1'b0; i_valid = 1'b0; i_data = '0; i_stall = 1'b0;
`ifdef TU_EARLY_TERM_EN
    cfg_len_log2 = 2'd0;
`endif
    step(); step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_single();
    test_neg_zero();
    test_back_to_back();
    test_stall();
    test_clr();
    test_async_reset();
`ifdef TU_EARLY_TERM_EN
    test_early_term();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
